// File: rtl/capture_fifo.sv
// rtl/capture_fifo.sv - capture buffer FIFO with collect/drain/done sequencing
// Optional feature: define CAPTURE_FIFO_MAX_TRACK_EN to add the cap_max output
// (running unsigned maximum of accepted captures).

module capture_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_valid,
  input  logic [WIDTH-1:0]         cap_data,
  input  logic                     cap_done,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [1:0]               state
`ifdef CAPTURE_FIFO_MAX_TRACK_EN
  ,
  output logic [WIDTH-1:0]         cap_max
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic accepting;
  logic full;
  logic pop;
  logic wr_en;
  logic drop;

  // Handshake decode: reset masks both pops and writes in the same cycle
  always_comb begin
    accepting = (state_q == IDLE) || (state_q == COLLECT);
    full      = (level_q == LW'(DEPTH));
    pop       = (level_q != '0) && rd_ready && !rst;
    wr_en     = cap_valid && accepting && (!full || pop) && !rst;
    drop      = cap_valid && accepting && full && !pop && !rst;
  end

  // Next-state, pointer, level and sticky overflow computation
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q || drop;

    case (state_q)
      IDLE: begin
        if (cap_done)       state_d = DRAIN;
        else if (cap_valid) state_d = COLLECT;
      end
      COLLECT: if (cap_done) state_d = DRAIN;
      // Level is the registered value, so DONE lands one cycle after the last pop
      DRAIN:   if (level_q == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are not reset, only the pointers are
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= cap_data;
  end

  assign rd_valid = (level_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;
  assign state    = state_q;

`ifdef CAPTURE_FIFO_MAX_TRACK_EN
  logic [WIDTH-1:0] cap_max_q, cap_max_d;

  // Running maximum follows only captures that were actually stored
  always_comb begin
    cap_max_d = cap_max_q;
    if (wr_en && (cap_data > cap_max_q)) cap_max_d = cap_data;
  end

  // Maximum register
  always_ff @(posedge clk) begin
    if (rst) cap_max_q <= '0;
    else     cap_max_q <= cap_max_d;
  end

  assign cap_max = cap_max_q;
`endif

endmodule

// File: tb/tb_capture_fifo.sv
// tb/tb_capture_fifo.sv - directed self-checking bench for capture_fifo

module tb_capture_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        cap_valid;
  logic [15:0] cap_data;
  logic        cap_done;
  logic        rd_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [3:0]  level;
  logic        overflow;
  logic [1:0]  state;
`ifdef CAPTURE_FIFO_MAX_TRACK_EN
  logic [15:0] cap_max;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  capture_fifo #(.WIDTH(16), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cap_valid(cap_valid),
    .cap_data (cap_data),
    .cap_done (cap_done),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .level    (level),
    .overflow (overflow),
    .state    (state)
`ifdef CAPTURE_FIFO_MAX_TRACK_EN
    ,
    .cap_max  (cap_max)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    cap_valid = 1'b1;
    cap_data  = v;
    tick();
    cap_valid = 1'b0;
  endtask

  task automatic pop_exp(input string tag, input logic [15:0] e);
    rd_ready = 1'b1;
    check(tag, 32'(rd_data), 32'(e));
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cap_valid = 1'b0; cap_data = '0; cap_done = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_state",    32'(state),    32'd0);
    check("rst_level",    32'(level),    32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Three captures, no consumer
    push(16'd5);
    check("lat1_rd_valid", 32'(rd_valid), 32'd1);
    check("lat1_state",    32'(state),    32'd1);
    push(16'd6);
    push(16'd7);
    check("c3_state",   32'(state),   32'd1);
    check("c3_level",   32'(level),   32'd3);
    check("c3_rd_data", 32'(rd_data), 32'd5);

    // Fill to full, then a dropped capture
    for (int i = 8; i <= 12; i++) push(16'(i));
    check("full_level", 32'(level), 32'd8);
    check("full_ovf0",  32'(overflow), 32'd0);
    push(16'd99);
    check("drop_level", 32'(level),    32'd8);
    check("drop_ovf",   32'(overflow), 32'd1);
    pop_exp("drain_a0", 16'd5);
    pop_exp("drain_a1", 16'd6);
    pop_exp("drain_a2", 16'd7);
    for (int i = 8; i <= 12; i++) pop_exp("drain_a", 16'(i));
    check("empty_level",    32'(level),    32'd0);
    check("empty_rd_valid", 32'(rd_valid), 32'd0);
    check("ovf_sticky",     32'(overflow), 32'd1);

    // Full buffer with simultaneous pop and write
    do_reset();
    for (int i = 1; i <= 8; i++) push(16'(i));
    rd_ready = 1'b1; cap_valid = 1'b1; cap_data = 16'd42;
    check("both_rd_data", 32'(rd_data), 32'd1);
    tick();
    rd_ready = 1'b0; cap_valid = 1'b0;
    check("both_level", 32'(level),    32'd8);
    check("both_ovf",   32'(overflow), 32'd0);
    for (int i = 2; i <= 8; i++) pop_exp("both_seq", 16'(i));
    pop_exp("both_42", 16'd42);
    check("both_end_level", 32'(level), 32'd0);

    // Collect, drain, done
    do_reset();
    push(16'd10); push(16'd20); push(16'd30);
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
    check("drain_state", 32'(state), 32'd2);
    pop_exp("drain_b0", 16'd10);
    pop_exp("drain_b1", 16'd20);
    check("drain_mid_state", 32'(state), 32'd2);
    pop_exp("drain_b2", 16'd30);
    check("drain_lvl0_state", 32'(state), 32'd2);
    tick();
    check("done_state", 32'(state), 32'd3);
    push(16'd77);
    check("done_ign_level", 32'(level),    32'd0);
    check("done_ign_ovf",   32'(overflow), 32'd0);
    tick(); tick();
    check("done_hold", 32'(state), 32'd3);

    // Capture coincident with cap_done from IDLE
    do_reset();
    cap_valid = 1'b1; cap_done = 1'b1; cap_data = 16'd55;
    tick();
    cap_valid = 1'b0; cap_done = 1'b0;
    check("cd_state",   32'(state),   32'd2);
    check("cd_level",   32'(level),   32'd1);
    check("cd_rd_data", 32'(rd_data), 32'd55);
    push(16'd66);
    check("drain_ign_level", 32'(level),    32'd1);
    check("drain_ign_ovf",   32'(overflow), 32'd0);

    // Reset in the middle of DRAIN
    do_reset();
    for (int i = 1; i <= 8; i++) push(16'(i));
    push(16'd99);
    for (int i = 1; i <= 4; i++) pop_exp("pre_rst", 16'(i));
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
    check("pre_rst_state", 32'(state),    32'd2);
    check("pre_rst_level", 32'(level),    32'd4);
    check("pre_rst_ovf",   32'(overflow), 32'd1);
    rst = 1'b1; rd_ready = 1'b1; cap_valid = 1'b1; cap_data = 16'd123;
    tick();
    rst = 1'b0; rd_ready = 1'b0; cap_valid = 1'b0;
    check("mid_rst_state",    32'(state),    32'd0);
    check("mid_rst_level",    32'(level),    32'd0);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_ovf",      32'(overflow), 32'd0);

`ifdef CAPTURE_FIFO_MAX_TRACK_EN
    do_reset();
    check("max_rst", 32'(cap_max), 32'd0);
    push(16'd3);
    check("max_3", 32'(cap_max), 32'd3);
    push(16'd499);
    push(16'd17);
    check("max_499", 32'(cap_max), 32'd499);
    for (int i = 1; i <= 5; i++) push(16'(i));
    push(16'd600);
    check("max_drop_ovf", 32'(overflow), 32'd1);
    check("max_drop",     32'(cap_max),  32'd499);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
